// File: rtl/c_d_buffer_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : hierIncludeCInclude_package
//  Purpose  : Shared types and constants for the hierInclude C hierarchy.
//             Holds the d-word type, the C occupancy state type and the
//             occupancy-state encodings used by c_d_buffer.
//  Revision : 1.0  initial release of c_d_buffer support constants
// ============================================================================
package hierIncludeCInclude_package;

  localparam int D_SIZE         = 3;
  localparam int C_ANOTHER_SIZE = 10;

  typedef logic [D_SIZE-1:0] dT;
  typedef logic [3:0]        cStateT;

  localparam cStateT C_BUF_IDLE   = 4'd0;
  localparam cStateT C_BUF_ACTIVE = 4'd1;
  localparam cStateT C_BUF_FULL   = 4'd2;
  localparam cStateT C_BUF_FLUSH  = 4'd3;

  // Occupancy state implied by a given entry count
  function automatic cStateT cBufStateFromCount(input int unsigned cnt,
                                                input int unsigned depth);
    cStateT s;
    if (cnt == 0)            s = C_BUF_IDLE;
    else if (cnt >= depth)   s = C_BUF_FULL;
    else                     s = C_BUF_ACTIVE;
    return s;
  endfunction

endpackage
`default_nettype wire

// File: rtl/c_d_buffer_ptr.sv
`default_nettype none
// ============================================================================
//  Module   : c_buf_ptr
//  Purpose  : Circular index for a DEPTH-entry store. Advances on inc, wraps
//             from DEPTH-1 to 0 explicitly so non-power-of-2 depths work.
//             clr has priority over inc.
//  Revision : 1.0  initial release
// ============================================================================
module c_buf_ptr #(
  parameter int DEPTH = 10
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     inc,
  input  logic                     clr,
  output logic [$clog2(DEPTH)-1:0] ptr
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W-1:0] C_LAST = PTR_W'(DEPTH - 1);

  logic [PTR_W-1:0] r_ptr;

  // Pointer register: clear, or advance with explicit wrap at the last entry
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ptr <= '0;
    end else if (clr) begin
      r_ptr <= '0;
    end else if (inc) begin
      r_ptr <= (r_ptr == C_LAST) ? '0 : r_ptr + 1'b1;
    end
  end

  assign ptr = r_ptr;

endmodule
`default_nettype wire

// File: rtl/c_d_buffer.sv
`default_nettype none
// ============================================================================
//  Module   : c_d_buffer
//  Purpose  : DEPTH-entry first-word-fall-through buffer of d-words with
//             valid/ready on both sides, synchronous flush, almost-full flag
//             and an exported cStateT occupancy state.
//  Options  : C_D_BUFFER_HWM_EN - adds the hwm (high-water mark) port.
//  Revision : 1.0  initial release
// ============================================================================
module c_d_buffer
  import hierIncludeCInclude_package::*;
#(
  parameter int WIDTH        = D_SIZE,
  parameter int DEPTH        = C_ANOTHER_SIZE,
  parameter int AFULL_THRESH = DEPTH - 2
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push_valid,
  output logic                       push_ready,
  input  logic [WIDTH-1:0]           push_data,
  output logic                       pop_valid,
  input  logic                       pop_ready,
  output logic [WIDTH-1:0]           pop_data,
  input  logic                       flush,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       almost_full,
  output cStateT                     state
`ifdef C_D_BUFFER_HWM_EN
  ,
  output logic [$clog2(DEPTH+1)-1:0] hwm
`endif
);

  localparam int CNT_W = $clog2(DEPTH+1);
  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [CNT_W-1:0] C_FULL_CNT  = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] C_AFULL_CNT = CNT_W'(AFULL_THRESH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] w_rdPtr;
  logic [PTR_W-1:0] w_wrPtr;
  logic [CNT_W-1:0] r_count;
  logic [CNT_W-1:0] w_nextCount;
  logic             r_almostFull;
  cStateT           r_state;
  logic             w_pushFire;
  logic             w_popFire;
  logic             w_pushTake;
  logic             w_popTake;

  // Handshakes depend on registered state only, so no ready-to-ready path
  assign push_ready = (r_state != C_BUF_FULL) && (r_state != C_BUF_FLUSH);
  assign pop_valid  = (r_count != '0) && (r_state != C_BUF_FLUSH);
  assign w_pushFire = push_valid && push_ready;
  assign w_popFire  = pop_valid && pop_ready;

  // A flush swallows any transfer in the same cycle; the count guard keeps
  // a corrupted state encoding from ever overrunning the store
  assign w_pushTake = w_pushFire && !flush && (r_count != C_FULL_CNT);
  assign w_popTake  = w_popFire && !flush;

  // Occupancy after this cycle's transfers
  always_comb begin
    w_nextCount = r_count;
    if (flush) begin
      w_nextCount = '0;
    end else if (w_pushTake && !w_popTake) begin
      w_nextCount = r_count + 1'b1;
    end else if (w_popTake && !w_pushTake) begin
      w_nextCount = r_count - 1'b1;
    end
  end

  c_buf_ptr #(.DEPTH(DEPTH)) u_rdPtr (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (w_popTake),
    .clr   (flush),
    .ptr   (w_rdPtr)
  );

  c_buf_ptr #(.DEPTH(DEPTH)) u_wrPtr (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (w_pushTake),
    .clr   (flush),
    .ptr   (w_wrPtr)
  );

  // Storage array, intentionally not reset
  always_ff @(posedge clk) begin
    if (w_pushTake) begin
      r_mem[w_wrPtr] <= push_data;
    end
  end

  assign pop_data = r_mem[w_rdPtr];

  // Occupancy FSM with registered count and almost-full flag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count      <= '0;
      r_almostFull <= 1'b0;
      r_state      <= C_BUF_IDLE;
    end else begin
      r_count      <= w_nextCount;
      r_almostFull <= (w_nextCount >= C_AFULL_CNT);
      if (flush) begin
        r_state <= C_BUF_FLUSH;
      end else begin
        case (r_state)
          C_BUF_IDLE,
          C_BUF_ACTIVE,
          C_BUF_FULL,
          C_BUF_FLUSH: r_state <= cBufStateFromCount(32'(w_nextCount), DEPTH);
          default:     r_state <= C_BUF_IDLE;
        endcase
      end
    end
  end

  assign count       = r_count;
  assign almost_full = r_almostFull;
  assign state       = r_state;

`ifdef C_D_BUFFER_HWM_EN
  logic [CNT_W-1:0] r_hwm;

  // Peak occupancy since reset; deliberately survives flush
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_hwm <= '0;
    end else if (w_nextCount > r_hwm) begin
      r_hwm <= w_nextCount;
    end
  end

  assign hwm = r_hwm;
`endif

endmodule
`default_nettype wire

// File: tb/tb_c_d_buffer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_c_d_buffer
//  Purpose  : Directed self-checking bench for c_d_buffer (DEPTH=10, WIDTH=3).
//             Define C_D_BUFFER_HWM_EN to include the high-water-mark test.
//  Revision : 1.0  initial release
// ============================================================================
module tb_c_d_buffer;
  import hierIncludeCInclude_package::*;

  localparam int DEPTH = 10;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       push_valid = 1'b0;
  logic       push_ready;
  logic [2:0] push_data = 3'd0;
  logic       pop_valid;
  logic       pop_ready = 1'b0;
  logic [2:0] pop_data;
  logic       flush = 1'b0;
  logic [3:0] count;
  logic       almost_full;
  cStateT     state;
`ifdef C_D_BUFFER_HWM_EN
  logic [3:0] hwm;
`endif

  int nVec  = 0;
  int nFail = 0;

  always #5 clk = ~clk;

  c_d_buffer dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .push_valid  (push_valid),
    .push_ready  (push_ready),
    .push_data   (push_data),
    .pop_valid   (pop_valid),
    .pop_ready   (pop_ready),
    .pop_data    (pop_data),
    .flush       (flush),
    .count       (count),
    .almost_full (almost_full),
    .state       (state)
`ifdef C_D_BUFFER_HWM_EN
    ,
    .hwm         (hwm)
`endif
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; push_valid = 1'b0; pop_ready = 1'b0; flush = 1'b0;
    step(); step();
    nVec++; if (push_ready !== 1'b1) begin nFail++; $display("FAIL rst_push_ready: got %b want 1", push_ready); end
    nVec++; if (pop_valid !== 1'b0) begin nFail++; $display("FAIL rst_pop_valid: got %b want 0", pop_valid); end
    nVec++; if (count !== 4'd0) begin nFail++; $display("FAIL rst_count: got %0d want 0", count); end
    nVec++; if (state !== C_BUF_IDLE) begin nFail++; $display("FAIL rst_state: got %0d want 0", state); end
    nVec++; if (almost_full !== 1'b0) begin nFail++; $display("FAIL rst_afull: got %b want 0", almost_full); end
`ifdef C_D_BUFFER_HWM_EN
    nVec++; if (hwm !== 4'd0) begin nFail++; $display("FAIL rst_hwm: got %0d want 0", hwm); end
`endif
    rst_n = 1'b1;
    step();
    // traffic, then an asynchronous reset between clock edges
    push_valid = 1'b1; push_data = 3'd5;
    step(); step(); step();
    nVec++; if (count !== 4'd3) begin nFail++; $display("FAIL pre_rst_count: got %0d want 3", count); end
    #2;
    rst_n = 1'b0;
    #1;
    nVec++; if (push_ready !== 1'b1) begin nFail++; $display("FAIL mid_rst_push_ready: got %b want 1", push_ready); end
    nVec++; if (pop_valid !== 1'b0) begin nFail++; $display("FAIL mid_rst_pop_valid: got %b want 0", pop_valid); end
    nVec++; if (count !== 4'd0) begin nFail++; $display("FAIL mid_rst_count: got %0d want 0", count); end
    nVec++; if (state !== C_BUF_IDLE) begin nFail++; $display("FAIL mid_rst_state: got %0d want 0", state); end
    push_valid = 1'b0;
    step();
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_fill();
    pop_ready = 1'b0; push_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      push_data = 3'((i + 1) % 8);
      step();
      nVec++; if (count !== 4'(i + 1)) begin nFail++; $display("FAIL fill_count[%0d]: got %0d want %0d", i, count, i + 1); end
      nVec++; if (almost_full !== ((i + 1) >= 8)) begin nFail++; $display("FAIL fill_afull[%0d]: got %b want %b", i, almost_full, ((i + 1) >= 8)); end
      if (i == 0) begin
        nVec++; if (pop_valid !== 1'b1) begin nFail++; $display("FAIL fwft_valid: got %b want 1", pop_valid); end
        nVec++; if (pop_data !== 3'd1) begin nFail++; $display("FAIL fwft_data: got %0d want 1", pop_data); end
      end
    end
    push_valid = 1'b0;
    nVec++; if (state !== C_BUF_FULL) begin nFail++; $display("FAIL fill_state: got %0d want 2", state); end
    nVec++; if (push_ready !== 1'b0) begin nFail++; $display("FAIL fill_push_ready: got %b want 0", push_ready); end
    nVec++; if (pop_data !== 3'd1) begin nFail++; $display("FAIL fill_head: got %0d want 1", pop_data); end
  endtask

  task automatic test_full_simultaneous();
    logic [2:0] expd [9] = '{3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7, 3'd0, 3'd1, 3'd2};
    push_valid = 1'b1; push_data = 3'd5; pop_ready = 1'b1;
    step();
    push_valid = 1'b0;
    nVec++; if (count !== 4'd9) begin nFail++; $display("FAIL fullsim_count: got %0d want 9", count); end
    nVec++; if (state !== C_BUF_ACTIVE) begin nFail++; $display("FAIL fullsim_state: got %0d want 1", state); end
    nVec++; if (push_ready !== 1'b1) begin nFail++; $display("FAIL fullsim_push_ready: got %b want 1", push_ready); end
    for (int k = 0; k < 9; k++) begin
      nVec++; if (pop_valid !== 1'b1) begin nFail++; $display("FAIL drain_valid[%0d]: got %b want 1", k, pop_valid); end
      nVec++; if (pop_data !== expd[k]) begin nFail++; $display("FAIL drain_data[%0d]: got %0d want %0d", k, pop_data, expd[k]); end
      step();
    end
    pop_ready = 1'b0;
    nVec++; if (pop_valid !== 1'b0) begin nFail++; $display("FAIL drain_empty_valid: got %b want 0", pop_valid); end
    nVec++; if (count !== 4'd0) begin nFail++; $display("FAIL drain_count: got %0d want 0", count); end
    nVec++; if (state !== C_BUF_IDLE) begin nFail++; $display("FAIL drain_state: got %0d want 0", state); end
  endtask

  task automatic test_wrap();
    logic [2:0] q[$];
    int sent = 0;
    int recv = 0;
    int cyc  = 0;
    while (recv < 25 && cyc < 2000) begin
      nVec++; if (count !== 4'(q.size())) begin nFail++; $display("FAIL wrap_count: got %0d want %0d", count, q.size()); end
      nVec++; if (push_ready !== (q.size() != DEPTH)) begin nFail++; $display("FAIL wrap_push_ready: got %b want %b", push_ready, (q.size() != DEPTH)); end
      nVec++; if (pop_valid !== (q.size() != 0)) begin nFail++; $display("FAIL wrap_pop_valid: got %b want %b", pop_valid, (q.size() != 0)); end
      push_valid = (sent < 25) && ($urandom_range(0, 3) != 0);
      push_data  = 3'(sent * 3 + 1);
      pop_ready  = ($urandom_range(0, 2) != 0);
      if (pop_valid && pop_ready) begin
        nVec++;
        if (q.size() == 0) begin
          nFail++; $display("FAIL wrap_underflow: got word %0d want none", pop_data);
        end else begin
          if (pop_data !== q[0]) begin nFail++; $display("FAIL wrap_order[%0d]: got %0d want %0d", recv, pop_data, q[0]); end
          void'(q.pop_front());
        end
        recv++;
      end
      if (push_valid && push_ready) begin
        q.push_back(push_data);
        sent++;
      end
      step();
      cyc++;
    end
    nVec++; if (recv < 25) begin nFail++; $display("FAIL wrap_timeout: got %0d words want 25", recv); end
    push_valid = 1'b0; pop_ready = 1'b0;
    // drain any leftovers so later tests start empty
    pop_ready = 1'b1;
    for (int k = 0; k < DEPTH + 1; k++) step();
    pop_ready = 1'b0;
  endtask

  task automatic test_flush();
    push_valid = 1'b1;
    for (int i = 0; i < 6; i++) begin
      push_data = 3'((i + 4) % 8);
      step();
    end
    nVec++; if (count !== 4'd6) begin nFail++; $display("FAIL flush_pre_count: got %0d want 6", count); end
    nVec++; if (state !== C_BUF_ACTIVE) begin nFail++; $display("FAIL flush_pre_state: got %0d want 1", state); end
    flush = 1'b1; push_data = 3'd7; pop_ready = 1'b1;
    step();
    flush = 1'b0; push_valid = 1'b0; pop_ready = 1'b0;
    nVec++; if (state !== C_BUF_FLUSH) begin nFail++; $display("FAIL flush_state: got %0d want 3", state); end
    nVec++; if (count !== 4'd0) begin nFail++; $display("FAIL flush_count: got %0d want 0", count); end
    nVec++; if (push_ready !== 1'b0) begin nFail++; $display("FAIL flush_push_ready: got %b want 0", push_ready); end
    nVec++; if (pop_valid !== 1'b0) begin nFail++; $display("FAIL flush_pop_valid: got %b want 0", pop_valid); end
    nVec++; if (almost_full !== 1'b0) begin nFail++; $display("FAIL flush_afull: got %b want 0", almost_full); end
    step();
    nVec++; if (state !== C_BUF_IDLE) begin nFail++; $display("FAIL post_flush_state: got %0d want 0", state); end
    nVec++; if (push_ready !== 1'b1) begin nFail++; $display("FAIL post_flush_push_ready: got %b want 1", push_ready); end
    push_valid = 1'b1; push_data = 3'd2;
    step();
    push_valid = 1'b0;
    nVec++; if (count !== 4'd1) begin nFail++; $display("FAIL refill_count: got %0d want 1", count); end
    nVec++; if (pop_data !== 3'd2) begin nFail++; $display("FAIL refill_head: got %0d want 2", pop_data); end
    // flush held for two cycles stays in FLUSH
    flush = 1'b1;
    step(); step();
    nVec++; if (state !== C_BUF_FLUSH) begin nFail++; $display("FAIL flush_hold_state: got %0d want 3", state); end
    flush = 1'b0;
    step();
    nVec++; if (state !== C_BUF_IDLE) begin nFail++; $display("FAIL flush_release_state: got %0d want 0", state); end
    nVec++; if (count !== 4'd0) begin nFail++; $display("FAIL flush_release_count: got %0d want 0", count); end
  endtask

`ifdef C_D_BUFFER_HWM_EN
  task automatic test_hwm();
    rst_n = 1'b0;
    step();
    nVec++; if (hwm !== 4'd0) begin nFail++; $display("FAIL hwm_reset: got %0d want 0", hwm); end
    rst_n = 1'b1;
    step();
    push_valid = 1'b1;
    for (int i = 0; i < 7; i++) begin push_data = 3'(i); step(); end
    push_valid = 1'b0;
    nVec++; if (hwm !== 4'd7) begin nFail++; $display("FAIL hwm_peak: got %0d want 7", hwm); end
    flush = 1'b1; step(); flush = 1'b0; step();
    push_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin push_data = 3'(i); step(); end
    push_valid = 1'b0;
    nVec++; if (count !== 4'd4) begin nFail++; $display("FAIL hwm_refill_count: got %0d want 4", count); end
    nVec++; if (hwm !== 4'd7) begin nFail++; $display("FAIL hwm_after_flush: got %0d want 7", hwm); end
  endtask
`endif

  initial begin
    test_reset();
    test_fill();
    test_full_simultaneous();
    test_wrap();
    test_flush();
`ifdef C_D_BUFFER_HWM_EN
    test_hwm();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", nVec, nFail);
    $finish;
  end

endmodule
`default_nettype wire
